mac_array_sched: RTL

Tile scheduler for the MAC compute array. Accepts one GEMM-tile job per command handshake, issues weight/activation buffer reads for K consecutive K-tiles, broadcasts the precision mode to the array's `ctrl` inputs, and steers the array's `acc` feedback. It also raises the output-buffer write strobe when the final accumulated result is present. It sits between the command decoder and the array/buffers and is the only driver of array `ctrl` and accumulator control.

---
 rtl/mac_sched_pkg.sv | 27 ++
 rtl/mac_sched_tagpipe.sv | 31 +++
 rtl/mac_array_sched.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mac_sched_pkg.sv
// Shared types for the MAC array tile scheduler.
//   mode_e  : precision mode carried on cmd_mode / arr_ctrl
//   state_e : scheduler FSM states
//   tag_t   : per-tile marker travelling alongside the operands
package mac_sched_pkg;

  typedef enum logic [1:0] {
    MODE_INT4    = 2'b00,
    MODE_INT8    = 2'b01,
    MODE_INT16   = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/mac_sched_tagpipe.sv
// Fixed-depth shift register of tile tags, matching the buffer-read plus
// array latency so that each tag emerges together with its array result.
//   clk     : clock, rising edge
//   clr_n   : asynchronous active-low clear (flushes all stages)
//   tag_in  : tag of the tile whose read is issued this cycle
//   tag_out : tag of the tile whose result is at the array output
module mac_sched_tagpipe
  import mac_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic clr_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mac_array_sched.sv
// Tile scheduler for the MAC compute array. Accepts one GEMM-tile job per
// command handshake, issues K consecutive weight/activation reads, broadcasts
// the precision mode and steers the external accumulator register.
//   clk, reset                  : clock, async active-low reset
//   cmd_valid/cmd_ready         : command handshake (ready only in IDLE)
//   cmd_mode, cmd_ktiles        : precision mode, number of K-tiles
//   cmd_wbase/abase/obase       : weight, activation, output base addresses
//   wbuf_re/addr, abuf_re/addr  : buffer read port controls
//   arr_ctrl                    : mode broadcast to the array
//   acc_zero, acc_en            : accumulator feedback select / capture
//   out_we, out_addr            : output buffer write strobe / address
//   busy, done, err             : job status
module mac_array_sched
  import mac_sched_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [CNT_W-1:0]  cmd_ktiles,
  input  logic [ADDR_W-1:0] cmd_wbase,
  input  logic [ADDR_W-1:0] cmd_abase,
  input  logic [ADDR_W-1:0] cmd_obase,
  output logic              wbuf_re,
  output logic              abuf_re,
  output logic [ADDR_W-1:0] wbuf_addr,
  output logic [ADDR_W-1:0] abuf_addr,
  output logic [1:0]        arr_ctrl,
  output logic              acc_zero,
  output logic              acc_en,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned L = RD_LAT + MAC_LAT;

  state_e           state, state_nx;
  logic             legal_cmd;
  logic             issue_last;
  logic             rd_en, first_q, last_q;
  logic [CNT_W-1:0] cnt, k_tot;
  tag_t             tag_in, tag_out;

  assign legal_cmd  = (mode_e'(cmd_mode) != MODE_ILLEGAL) && (cmd_ktiles != '0);
  // cnt counts reads issued including the one on the bus this cycle
  assign issue_last = (cnt == k_tot);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nx = legal_cmd ? S_ISSUE : S_DONE;
      S_ISSUE: if (issue_last) state_nx = S_DRAIN;
      // The last tile's tag leaving the pipe means nothing is left in flight.
      S_DRAIN: if (tag_out.valid && tag_out.last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign cmd_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      cnt       <= '0;
      k_tot     <= '0;
      wbuf_addr <= '0;
      abuf_addr <= '0;
      arr_ctrl  <= '0;
      out_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      busy <= (state_nx != S_IDLE);
      done <= (state_nx == S_DONE);
      // Only an illegal accept goes straight from IDLE to DONE.
      err  <= (state == S_IDLE) && cmd_valid && !legal_cmd;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            out_addr <= cmd_obase;
            k_tot    <= cmd_ktiles;
            if (legal_cmd) begin
              arr_ctrl  <= cmd_mode;
              rd_en     <= 1'b1;
              wbuf_addr <= cmd_wbase;
              abuf_addr <= cmd_abase;
              cnt       <= CNT_W'(1);
              first_q   <= 1'b1;
              last_q    <= (cmd_ktiles == CNT_W'(1));
            end
          end
        end
        S_ISSUE: begin
          if (issue_last) begin
            rd_en   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
          end else begin
            wbuf_addr <= wbuf_addr + ADDR_W'(1);
            abuf_addr <= abuf_addr + ADDR_W'(1);
            cnt       <= cnt + CNT_W'(1);
            first_q   <= 1'b0;
            last_q    <= ((cnt + CNT_W'(1)) == k_tot);
          end
        end
        default: ;
      endcase
    end
  end

  assign wbuf_re = rd_en;
  assign abuf_re = rd_en;

  assign tag_in = '{valid: rd_en, first: first_q, last: last_q};

  mac_sched_tagpipe #(.DEPTH(L)) u_tagpipe (
    .clk     (clk),
    .clr_n   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign acc_en   = tag_out.valid;
  assign acc_zero = tag_out.valid && tag_out.first;
  assign out_we   = tag_out.valid && tag_out.last;

endmodule
